// File: rtl/imm_pkg.sv
// Shared types and constants for the decode-stage immediate generator.
package imm_pkg;

    // Immediate formats as selected by the decoder.
    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_J    = 3'b011,
        IMM_U    = 3'b100,
        IMM_Z    = 3'b101,
        IMM_SH   = 3'b110,
        IMM_RSVD = 3'b111
    } imm_src_e;

    localparam int unsigned InstrW   = 32;
    localparam int unsigned SignBit  = 31;
    // MSB of the 6-bit shamt field; set only for RV64-style shifts.
    localparam int unsigned ShamtMsb = 25;

    function automatic bit xlen_legal(int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_format.sv
// Combinational immediate extraction: instruction word + format select -> extended immediate.
module imm_format
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [InstrW-1:0] instr_i,
    input  logic [2:0]        src_i,
    output logic [XLEN-1:0]   imm_o,
    output logic              illegal_o
);

    imm_src_e          src;
    logic [InstrW-1:0] raw;   // immediate already extended to 32 bits
    logic              sext;  // raw is signed and must be sign-extended to XLEN
    logic              unused_opcode;

    assign src           = imm_src_e'(src_i);
    assign unused_opcode = ^instr_i[6:0];

    // Decode the selected format into a 32-bit value plus its signedness.
    always_comb begin
        raw       = '0;
        sext      = 1'b0;
        illegal_o = 1'b0;
        unique case (src)
            IMM_I: begin
                raw  = {{20{instr_i[SignBit]}}, instr_i[31:20]};
                sext = 1'b1;
            end
            IMM_S: begin
                raw  = {{20{instr_i[SignBit]}}, instr_i[31:25], instr_i[11:7]};
                sext = 1'b1;
            end
            IMM_B: begin
                raw  = {{19{instr_i[SignBit]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
                sext = 1'b1;
            end
            IMM_J: begin
                raw  = {{11{instr_i[SignBit]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
                sext = 1'b1;
            end
            IMM_U: begin
                raw  = {instr_i[31:12], 12'b0};
                sext = 1'b1;
            end
            IMM_Z: begin
                raw = {27'b0, instr_i[19:15]};
            end
            IMM_SH: begin
                // A 32-bit datapath cannot shift by 32 or more.
                if (XLEN == 32 && instr_i[ShamtMsb]) begin
                    raw       = {27'b0, instr_i[24:20]};
                    illegal_o = 1'b1;
                end else begin
                    raw = {26'b0, instr_i[25:20]};
                end
            end
            IMM_RSVD: begin
                illegal_o = 1'b1;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    // Widen to the datapath.
    always_comb begin
        imm_o = sext ? XLEN'($signed(raw)) : XLEN'(raw);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake, optional 2-entry skid and flush.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned USE_SKID = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [2:0]        in_imm_src,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_target,
    output logic              out_illegal
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    // Beat payload layout: {illegal, target, imm}.
    localparam int unsigned PW = 2 * XLEN + 1;

    logic [XLEN-1:0] fmt_imm;
    logic            fmt_illegal;
    logic [PW-1:0]   beat;
    logic            in_fire;

    logic            main_valid_q, main_valid_d;
    logic [PW-1:0]   main_data_q, main_data_d;

    imm_format #(
        .XLEN (XLEN)
    ) u_imm_format (
        .instr_i   (in_instr),
        .src_i     (in_imm_src),
        .imm_o     (fmt_imm),
        .illegal_o (fmt_illegal)
    );

    assign beat    = {fmt_illegal, in_pc + fmt_imm, fmt_imm};
    assign in_fire = in_valid && in_ready;

    assign out_valid                           = main_valid_q;
    assign {out_illegal, out_target, out_imm}  = main_data_q;

    if (USE_SKID != 0) begin : g_skid
        logic          skid_valid_q, skid_valid_d;
        logic [PW-1:0] skid_data_q, skid_data_d;

        assign in_ready = !skid_valid_q;

        // Main/skid next state; skid is only ever occupied while main is valid.
        always_comb begin
            main_valid_d = main_valid_q;
            main_data_d  = main_data_q;
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (flush) begin
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end else if (!main_valid_q || out_ready) begin
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                end else if (in_fire) begin
                    main_valid_d = 1'b1;
                    main_data_d  = beat;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (in_fire) begin
                skid_valid_d = 1'b1;
                skid_data_d  = beat;
            end
        end

        // Skid register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                skid_valid_q <= 1'b0;
                skid_data_q  <= '0;
            end else begin
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
            end
        end
    end else begin : g_no_skid
        assign in_ready = !main_valid_q || out_ready;

        // Single stage: a new beat replaces the draining one without a bubble.
        always_comb begin
            main_valid_d = main_valid_q;
            main_data_d  = main_data_q;
            if (flush) begin
                main_valid_d = 1'b0;
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = beat;
            end else if (out_ready) begin
                main_valid_d = 1'b0;
            end
        end
    end

    // Output (main) register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end

endmodule
